bhv_1p_sram_bw: RTL and testbench

//   Parametrised behavioural single-port SRAM model for CNN weight/feature buffers.

---
 rtl/bhv_1p_sram_bw.sv | 121 ++++++++++++
 tb/tb_bhv_1p_sram_bw.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bhv_1p_sram_bw.sv
// bhv_1p_sram_bw: behavioural single-port SRAM with byte-write mask, pipelined read and init fill
// Ports:
//   clk        clock, all logic on posedge
//   rstn       asynchronous active-low reset
//   a          address
//   cen        active-low chip enable (read strobe)
//   wen        active-low write enable
//   bwen       active-low byte write mask, bit i -> d[8i+7:8i]
//   d          write data
//   q          read data, holds last read word
//   qv         1-cycle pulse when q carries fresh read data
//   init_busy  high while the init sequencer owns the array
//   oor_err    1-cycle pulse after an access with a >= DEPTH
module bhv_1p_sram_bw #(
    parameter int               WWORD    = 32,
    parameter int               WADDR    = 10,
    parameter int               DEPTH    = 1000,
    parameter int               RD_LAT   = 1,
    parameter int               INIT_EN  = 1,
    parameter logic [WWORD-1:0] INIT_VAL = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WADDR-1:0]   a,
    input  logic               cen,
    input  logic               wen,
    input  logic [WWORD/8-1:0] bwen,
    input  logic [WWORD-1:0]   d,
    output logic [WWORD-1:0]   q,
    output logic               qv,
    output logic               init_busy,
    output logic               oor_err
);
    localparam int               NB      = WWORD / 8;
    localparam logic [0:0]       ST_INIT = 1'b0;
    localparam logic [0:0]       ST_RUN  = 1'b1;
    localparam logic [WADDR:0]   DEPTH_W = (WADDR + 1)'(DEPTH);
    localparam logic [WADDR-1:0] LAST    = WADDR'(DEPTH - 1);

    // Sized to the full address space so any address indexes cleanly; only 0..DEPTH-1 is used.
    logic [WWORD-1:0] mem [2**WADDR];
    logic [0:0]       state_q, state_d;
    logic [WADDR-1:0] cnt_q, cnt_d;
    logic             run, in_rng, rd, wr;
    logic [WWORD-1:0] rdata;
    logic             lv;
    logic [WWORD-1:0] ld;
    logic [WWORD-1:0] q_q;
    logic             qv_q, oor_q;

    assign run    = state_q == ST_RUN;
    assign in_rng = {1'b0, a} < DEPTH_W;
    assign rd     = run && !cen;
    assign wr     = rstn && run && !wen && in_rng;
    assign rdata  = in_rng ? mem[a] : '0;

    always_comb begin
        state_d = (!run && cnt_q == LAST) ? ST_RUN : state_q;
        cnt_d   = run ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array contents survive reset; the init sequencer is the only way to clear them.
    always_ff @(posedge clk) begin
        if (rstn && !run)
            mem[cnt_q] <= INIT_VAL;
        else if (wr)
            for (int i = 0; i < NB; i++)
                if (!bwen[i]) mem[a][8*i +: 8] <= d[8*i +: 8];
    end

    // The final stage is the q register itself, so the pipe ahead of it is RD_LAT-1 deep.
    if (RD_LAT == 1) begin : g_direct
        assign lv = rd;
        assign ld = rdata;
    end else begin : g_pipe
        logic [RD_LAT-2:0] pv_q;
        logic [WWORD-1:0]  pd_q [RD_LAT-1];
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                pv_q <= '0;
                for (int i = 0; i < RD_LAT - 1; i++) pd_q[i] <= '0;
            end else begin
                pv_q[0] <= rd;
                pd_q[0] <= rdata;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    pv_q[i] <= pv_q[i-1];
                    pd_q[i] <= pd_q[i-1];
                end
            end
        end
        assign lv = pv_q[RD_LAT-2];
        assign ld = pd_q[RD_LAT-2];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q   <= '0;
            qv_q  <= 1'b0;
            oor_q <= 1'b0;
        end else begin
            q_q   <= lv ? ld : q_q;
            qv_q  <= lv;
            oor_q <= run && !in_rng && (!cen || !wen);
        end
    end

    assign q         = q_q;
    assign qv        = qv_q;
    assign oor_err   = oor_q;
    assign init_busy = !run;
endmodule

// File: tb/tb_bhv_1p_sram_bw.sv
// tb_bhv_1p_sram_bw: directed bench for bhv_1p_sram_bw with a cycle-level reference model
// Two instances share one stimulus bus:
//   A: DEPTH=16 in a 5-bit space, RD_LAT=3, init fill with A5A5A5A5
//   B: DEPTH=32 (full space), RD_LAT=1, no init fill
module tb_bhv_1p_sram_bw;
    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  a;
    logic        cen, wen;
    logic [3:0]  bwen;
    logic [31:0] d;
    logic [31:0] q_o [2];
    logic        qv_o [2], busy_o [2], oor_o [2];

    always #5 clk = ~clk;

    bhv_1p_sram_bw #(.WWORD(32), .WADDR(5), .DEPTH(16), .RD_LAT(3), .INIT_EN(1),
                     .INIT_VAL(32'hA5A5_A5A5)) u_a (
        .clk(clk), .rstn(rstn), .a(a), .cen(cen), .wen(wen), .bwen(bwen), .d(d),
        .q(q_o[0]), .qv(qv_o[0]), .init_busy(busy_o[0]), .oor_err(oor_o[0]));

    bhv_1p_sram_bw #(.WWORD(32), .WADDR(5), .DEPTH(32), .RD_LAT(1), .INIT_EN(0),
                     .INIT_VAL(32'h0)) u_b (
        .clk(clk), .rstn(rstn), .a(a), .cen(cen), .wen(wen), .bwen(bwen), .d(d),
        .q(q_o[1]), .qv(qv_o[1]), .init_busy(busy_o[1]), .oor_err(oor_o[1]));

    // Reference model: word array with per-byte "known" flags, and a calendar of
    // read results keyed by the edge on which they must appear.
    int          dep  [2] = '{16, 32};
    int          lat  [2] = '{3, 1};
    int          ien  [2] = '{1, 0};
    logic [31:0] ival [2] = '{32'hA5A5_A5A5, 32'h0};
    logic [31:0] mm [2][32];
    logic [3:0]  kn [2][32];
    int          busy_left [2];
    logic [31:0] q_e [2];
    logic [3:0]  qk_e [2];
    logic        qv_e [2], oor_e [2];
    logic        sv [2][8];
    logic [31:0] sd [2][8];
    logic [3:0]  sk [2][8];
    int          edge_n;
    int          nvec, nerr;

    function automatic logic [31:0] bm(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    task automatic model_edge();
        int  ai, s;
        bit  inr;
        ai = int'(a);
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                busy_left[k] = ien[k] != 0 ? dep[k] : 0;
                q_e[k] = '0; qk_e[k] = 4'hF; qv_e[k] = 1'b0; oor_e[k] = 1'b0;
                for (int j = 0; j < 8; j++) sv[k][j] = 1'b0;
            end else begin
                qv_e[k] = 1'b0; oor_e[k] = 1'b0;
                if (busy_left[k] > 0) begin
                    mm[k][dep[k] - busy_left[k]] = ival[k];
                    kn[k][dep[k] - busy_left[k]] = 4'hF;
                    busy_left[k]--;
                end else begin
                    inr = ai < dep[k];
                    if (!cen) begin
                        s = (edge_n + lat[k] - 1) % 8;
                        sv[k][s] = 1'b1;
                        sd[k][s] = inr ? mm[k][ai] : 32'h0;
                        sk[k][s] = inr ? kn[k][ai] : 4'hF;
                    end
                    if (!wen && inr)
                        for (int i = 0; i < 4; i++)
                            if (!bwen[i]) begin
                                mm[k][ai][8*i +: 8] = d[8*i +: 8];
                                kn[k][ai][i] = 1'b1;
                            end
                    oor_e[k] = (!cen || !wen) && !inr;
                end
                s = edge_n % 8;
                if (sv[k][s]) begin
                    qv_e[k] = 1'b1; q_e[k] = sd[k][s]; qk_e[k] = sk[k][s]; sv[k][s] = 1'b0;
                end
            end
        end
        edge_n++;
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk("init_busy", k, 32'(busy_o[k]), 32'(busy_left[k] > 0));
            chk("qv", k, 32'(qv_o[k]), 32'(qv_e[k]));
            chk("oor_err", k, 32'(oor_o[k]), 32'(oor_e[k]));
            chk("q", k, q_o[k] & bm(qk_e[k]), q_e[k] & bm(qk_e[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        cen = 1'b1; wen = 1'b1; bwen = 4'hF; a = '0; d = '0;
    endtask

    task automatic acc(input logic [4:0] aa, input logic cc, input logic ww,
                       input logic [3:0] bb, input logic [31:0] dd);
        a = aa; cen = cc; wen = ww; bwen = bb; d = dd;
        tick();
    endtask

    task automatic wait_qv(output logic [31:0] v);
        int n = 0;
        do begin
            idle();
            tick();
            n++;
        end while (!qv_o[0] && n < 10);
        chk("qv_wait", 0, 32'(qv_o[0]), 32'd1);
        v = q_o[0];
    endtask

    // Counts cycles from reset release until A drops init_busy, hammering the bus meanwhile.
    task automatic busy_count(output int n);
        n = 0;
        do begin
            a = 5'(n); cen = 1'b0; wen = 1'b0; bwen = 4'h0; d = {24'hC0FFEE, 8'(n)};
            tick();
            n++;
        end while (busy_o[0] && n < 100);
        idle();
    endtask

    task automatic read_all_a();
        for (int i = 0; i < 16; i++) acc(5'(i), 1'b0, 1'b1, 4'hF, 32'h0);
        idle();
        repeat (4) tick();
    endtask

    initial begin
        int          n, oc, ob;
        logic [31:0] v;
        logic [5:0]  pat;
        nvec = 0; nerr = 0; edge_n = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                mm[k][i] = '0; kn[k][i] = 4'h0;
            end
        rstn = 1'b0;
        idle();
        tick();
        tick();
        rstn = 1'b1;
        busy_count(n);
        chk("busy_len", 0, n, 16);
        read_all_a();
        chk("q_init", 0, q_o[0], 32'hA5A5_A5A5);

        acc(5'd3, 1'b1, 1'b0, 4'b0000, 32'h1122_3344);
        acc(5'd3, 1'b1, 1'b0, 4'b1010, 32'hFFFF_FFFF);
        acc(5'd3, 1'b0, 1'b1, 4'hF, 32'h0);
        wait_qv(v);
        chk("bytemask", 0, v, 32'h11FF_33FF);

        acc(5'd0, 1'b1, 1'b0, 4'h0, 32'h1111_1111);
        acc(5'd1, 1'b1, 1'b0, 4'h0, 32'h2222_2222);
        acc(5'd2, 1'b1, 1'b0, 4'h0, 32'h3333_3333);
        for (int j = 0; j < 6; j++) begin
            if (j < 3) begin
                a = 5'(j); cen = 1'b0; wen = 1'b1; bwen = 4'hF;
            end else idle();
            tick();
            pat[j] = qv_o[0];
        end
        chk("lat_pattern", 0, 32'(pat), 32'(6'b011100));
        chk("q_hold", 0, q_o[0], 32'h3333_3333);

        acc(5'd5, 1'b1, 1'b0, 4'h0, 32'h0000_CAFE);
        acc(5'd5, 1'b0, 1'b0, 4'h0, 32'hBEEF_0000);
        acc(5'd5, 1'b0, 1'b1, 4'hF, 32'h0);
        wait_qv(v);
        chk("rbw_old", 0, v, 32'h0000_CAFE);
        wait_qv(v);
        chk("rbw_new", 0, v, 32'hBEEF_0000);

        oc = 0; ob = 0;
        acc(5'd16, 1'b1, 1'b0, 4'h0, 32'hDEAD_BEEF); oc += int'(oor_o[0]); ob += int'(oor_o[1]);
        acc(5'd16, 1'b0, 1'b1, 4'hF, 32'h0);        oc += int'(oor_o[0]); ob += int'(oor_o[1]);
        acc(5'd31, 1'b0, 1'b0, 4'h0, 32'h1234_5678); oc += int'(oor_o[0]); ob += int'(oor_o[1]);
        idle();
        repeat (4) begin
            tick();
            oc += int'(oor_o[0]); ob += int'(oor_o[1]);
        end
        chk("oor_count", 0, oc, 3);
        chk("oor_count", 1, ob, 0);
        chk("q_oor", 0, q_o[0], 32'h0);
        read_all_a();

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (7) tick();
        rstn = 1'b0;
        tick();
        tick();
        chk("busy_in_reset", 0, 32'(busy_o[0]), 32'd1);
        rstn = 1'b1;
        busy_count(n);
        chk("busy_len_restart", 0, n, 16);
        read_all_a();
        chk("q_refill", 0, q_o[0], 32'hA5A5_A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
